// File: rtl/dff_response_checker_if.sv
// dff_response_checker_if
//   Groups the observed flip-flop signals, the checker controls and the
//   checker results into one bundle.
//   master : drives Enable/Clear and the observed DUT signals, reads results
//   slave  : the checker itself
//   Observed inputs : D_obs, Dut_reset, Q_obs, Qbar_obs
//   Controls        : Enable (run checking), Clear (sync clear of results)
//   Results         : Checking, Err_pulse, Err_flag, Halted,
//                     Err_count, Check_count, Toggle_count, First_err_idx
interface dff_response_checker_if #(
  parameter int CNT_W = 16
);
  logic             Enable;
  logic             Clear;
  logic             D_obs;
  logic             Dut_reset;
  logic             Q_obs;
  logic             Qbar_obs;
  logic             Checking;
  logic             Err_pulse;
  logic             Err_flag;
  logic             Halted;
  logic [CNT_W-1:0] Err_count;
  logic [CNT_W-1:0] Check_count;
  logic [CNT_W-1:0] Toggle_count;
  logic [CNT_W-1:0] First_err_idx;

  modport master (
    output Enable, Clear, D_obs, Dut_reset, Q_obs, Qbar_obs,
    input  Checking, Err_pulse, Err_flag, Halted,
    input  Err_count, Check_count, Toggle_count, First_err_idx
  );

  modport slave (
    input  Enable, Clear, D_obs, Dut_reset, Q_obs, Qbar_obs,
    output Checking, Err_pulse, Err_flag, Halted,
    output Err_count, Check_count, Toggle_count, First_err_idx
  );
endinterface

// File: rtl/dff_response_checker.sv
// dff_response_checker
//   Output-side monitor for a single-bit D flip-flop with active-high reset.
//   Every clock it checks that Q equals the D sampled one edge earlier (or 0
//   while the flip-flop is, or just was, in reset) and that Qbar == ~Q.
//   Results are registered: edge k's evaluation is visible during cycle k+1.
//   Ports:
//     Clk   : checker clock, same clock as the observed flip-flop
//     Reset : asynchronous active-high reset of the checker
//     bus   : slave side of dff_response_checker_if (controls, observed
//             signals, counters and flags)
//   Parameters:
//     CNT_W       : width of all counters and First_err_idx
//     SETTLE      : edges spent in SETTLE before checking starts (1..15)
//     STOP_ON_ERR : 1 = freeze in HALT on the first mismatch
module dff_response_checker #(
  parameter int CNT_W       = 16,
  parameter int SETTLE      = 1,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  dff_response_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);

  state_t           state_reg, state_next;
  logic [3:0]       settle_cnt_reg, settle_cnt_next;
  logic             d_prev_reg, rst_prev_reg, q_prev_reg;
  logic [CNT_W-1:0] check_count_reg, check_count_next;
  logic [CNT_W-1:0] err_count_reg, err_count_next;
  logic [CNT_W-1:0] toggle_count_reg, toggle_count_next;
  logic [CNT_W-1:0] first_err_idx_reg, first_err_idx_next;
  logic             err_flag_reg, err_flag_next;
  logic             err_pulse_reg, err_pulse_next;

  logic expected_q;
  logic mismatch;
  logic check_edge;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Q must be 0 on the edge where the flip-flop's reset is high and on the
  // edge right after it (the flip-flop has not yet captured D again).
  assign expected_q = (bus.Dut_reset | rst_prev_reg) ? 1'b0 : d_prev_reg;
  assign mismatch   = (bus.Q_obs != expected_q) | (bus.Qbar_obs != ~bus.Q_obs);
  // Edges with Enable low leave CHECK unevaluated; Clear discards the edge.
  assign check_edge = (state_reg == ST_CHECK) & bus.Enable & ~bus.Clear;

  always_comb begin
    state_next         = state_reg;
    settle_cnt_next    = settle_cnt_reg;
    check_count_next   = check_count_reg;
    err_count_next     = err_count_reg;
    toggle_count_next  = toggle_count_reg;
    first_err_idx_next = first_err_idx_reg;
    err_flag_next      = err_flag_reg;
    err_pulse_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.Enable) begin
          state_next      = ST_SETTLE;
          settle_cnt_next = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!bus.Enable) begin
          state_next = ST_IDLE;
        end else if (settle_cnt_reg == 4'd0) begin
          state_next = ST_CHECK;
        end else begin
          settle_cnt_next = settle_cnt_reg - 1'b1;
        end
      end
      ST_CHECK: begin
        if (!bus.Enable) begin
          state_next = ST_IDLE;
        end else if (STOP_ON_ERR && check_edge && mismatch) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (bus.Clear) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (check_edge) begin
      check_count_next = sat_inc(check_count_reg);
      if (bus.Q_obs != q_prev_reg) begin
        toggle_count_next = sat_inc(toggle_count_reg);
      end
      if (mismatch) begin
        err_count_next = sat_inc(err_count_reg);
        err_pulse_next = 1'b1;
        if (!err_flag_reg) begin
          // Index of the failing check is the count before this edge.
          first_err_idx_next = check_count_reg;
          err_flag_next      = 1'b1;
        end
      end
    end

    if (bus.Clear) begin
      check_count_next   = '0;
      err_count_next     = '0;
      toggle_count_next  = '0;
      first_err_idx_next = '0;
      err_flag_next      = 1'b0;
      err_pulse_next     = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg         <= ST_IDLE;
      settle_cnt_reg    <= 4'd0;
      d_prev_reg        <= 1'b0;
      rst_prev_reg      <= 1'b0;
      q_prev_reg        <= 1'b0;
      check_count_reg   <= '0;
      err_count_reg     <= '0;
      toggle_count_reg  <= '0;
      first_err_idx_reg <= '0;
      err_flag_reg      <= 1'b0;
      err_pulse_reg     <= 1'b0;
    end else begin
      state_reg         <= state_next;
      settle_cnt_reg    <= settle_cnt_next;
      // History is captured in every state so the first checked edge after
      // SETTLE already has a valid d_prev.
      d_prev_reg        <= bus.D_obs;
      rst_prev_reg      <= bus.Dut_reset;
      q_prev_reg        <= bus.Q_obs;
      check_count_reg   <= check_count_next;
      err_count_reg     <= err_count_next;
      toggle_count_reg  <= toggle_count_next;
      first_err_idx_reg <= first_err_idx_next;
      err_flag_reg      <= err_flag_next;
      err_pulse_reg     <= err_pulse_next;
    end
  end

  assign bus.Checking      = (state_reg == ST_CHECK);
  assign bus.Halted        = (state_reg == ST_HALT);
  assign bus.Err_pulse     = err_pulse_reg;
  assign bus.Err_flag      = err_flag_reg;
  assign bus.Err_count     = err_count_reg;
  assign bus.Check_count   = check_count_reg;
  assign bus.Toggle_count  = toggle_count_reg;
  assign bus.First_err_idx = first_err_idx_reg;

endmodule

// File: doc/dff_response_checker.md
Name: dff_response_checker

Overview:
- Synthesizable output-side monitor for the single-bit D flip-flop with active-high reset used across the flip-flop/latch experiments.
- Watches the DUT's D input, async reset, Q and Qbar every clock.
- Checks each cycle that Q equals the D sampled one cycle earlier, or 0 under reset, and that Qbar equals ~Q.
- Counts checks, errors and Q toggles, and reports a sticky pass/fail so a board or bench can self-check without waveform inspection.

Parameters:
CNT_W, 16, width of Check_count, Err_count, Toggle_count and First_err_idx
SETTLE, 1, cycles skipped after Enable rises before checking starts (range 1..15)
STOP_ON_ERR, 0, 1 = freeze in HALT on the first error; 0 = keep checking

Ports:
Clk  input  1  checker clock, same clock as the DUT
Reset  input  1  asynchronous, active-high reset of the checker
Enable  input  1  run checking; low returns to IDLE with counters held
Clear  input  1  synchronous clear of counters and flags (priority below Reset)
D_obs  input  1  DUT D input
Dut_reset  input  1  DUT reset as driven
Q_obs  input  1  DUT Q
Qbar_obs  input  1  DUT Qbar
Checking  output  1  high while in CHECK
Err_pulse  output  1  one-cycle pulse per detected mismatch
Err_flag  output  1  sticky, set on first mismatch
Err_count  output  CNT_W  mismatches, saturating
Check_count  output  CNT_W  checked cycles, saturating
Toggle_count  output  CNT_W  Q transitions observed during CHECK, saturating
First_err_idx  output  CNT_W  Check_count value at first mismatch
Halted  output  1  high in HALT

Behaviour:
- Reset (async, any time, including mid-CHECK): state IDLE; all outputs, counters, d_prev, rst_prev, q_prev and settle counter go to 0 immediately.
- All other updates happen on posedge Clk.
- Clear: when high at an edge and Reset is low, counters, Err_flag, First_err_idx and Err_pulse go to 0; state is unchanged.
- Sampling: every edge registers d_prev<=D_obs, rst_prev<=Dut_reset and q_prev<=Q_obs in all states.
- Expected Q at edge k:
  - 0 if Dut_reset is high at edge k or rst_prev is high;
  - else d_prev.
- Mismatch at edge k: (Q_obs != expected) OR (Qbar_obs != ~Q_obs).
- State machine:
  - IDLE: Checking=0. Enable=1 -> SETTLE, settle counter loaded with SETTLE-1.
  - SETTLE: decrement; at 0 -> CHECK. Enable=0 -> IDLE.
  - CHECK: each edge evaluates mismatch. Enable=0 -> IDLE, and the edge where Enable is sampled low is not checked. Mismatch with STOP_ON_ERR=1 -> HALT.
  - HALT: Halted=1; counters frozen; only Reset or Clear leaves. Clear -> IDLE.
- Per checked edge in CHECK:
  - Check_count+1.
  - On mismatch:
    - Err_count+1;
    - Err_pulse=1 for the following cycle;
    - if Err_flag was 0, First_err_idx <= Check_count (pre-increment value) and Err_flag<=1.
  - If Q_obs != q_prev: Toggle_count+1.
- Latency: the outputs reflect edge k's evaluation during cycle k+1 (one register stage).
- Saturation: all counters stop at 2^CNT_W-1 and never wrap. Error detection and Err_flag continue to work when saturated.
- Simultaneous events:
  - Reset overrides all.
  - Clear and mismatch on the same edge: Clear wins; the counters read 0, not 1.
  - Enable falling and mismatch on the same edge: not counted.
- First edge after IDLE->CHECK uses d_prev captured during SETTLE, so no spurious error occurs on entry.

Test Plan:
1. Clk period 20 ns, Reset high 100 ns, Enable=1, ideal DFF model, DUT reset released at 100 ns, D toggling every 40 ns for 2000 ns -> Err_flag=0, Err_count=0, Toggle_count ~= Check_count/2 (±1), Check_count = number of checked edges.
2. Same run, but force Q_obs inverted for exactly one cycle at check index 37 -> Err_pulse high one cycle after the fault edge. Err_count=1 or 2: 1 for the fault edge; 2 if the forced value also differs on the next edge. First_err_idx=37, Err_flag=1.
3. Tie Qbar_obs=Q_obs for 3 checked edges, STOP_ON_ERR=1 -> Halted=1 after the first; Err_count=1; Check_count frozen; Clear returns the block to IDLE with all counters 0.
4. Pulse Dut_reset high for 1 cycle mid-run with D=1 while the DUT Q drops to 0 -> no error on the reset edge or the following edge. Q=1 during Dut_reset -> error.
5. CNT_W=4, continuous forced mismatch for 20 edges -> Err_count and Check_count hold at 15, no wrap, Err_flag=1.
6. Assert Reset asynchronously between edges mid-CHECK -> all outputs 0 before the next edge. Assert Clear on the same edge as a mismatch -> Err_count=0, Err_flag=0.
